spi_flash_cache: RTL

Direct-mapped, one-word-per-line read cache between the FemtoRV32 data/instruction port and the memory-mapped SPI flash reader. It serves repeated fetches from the execute-in-place program space (0x00000000–0x003FFFFF) in one cycle instead of a full SPI read transaction. A miss issues exactly one strobe to the flash reader and installs the returned word. Read-only: writes never reach this block.

---
 rtl/spi_flash_cache.sv | 113 +++++++++++
 1 files changed

// File: rtl/spi_flash_cache.sv
// Direct-mapped, one-word-per-line read cache in front of the SPI flash reader.
// Optional hit/miss counters are built when SPI_FLASH_CACHE_STATS_EN is defined.
module spi_flash_cache #(
  parameter int LINES  = 16,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rstrb,
  input  logic [ADDR_W-1:0] cpu_word_address,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_rbusy,
  output logic              flash_rstrb,
  output logic [ADDR_W-1:0] flash_word_address,
  input  logic [31:0]       flash_rdata,
  input  logic              flash_rbusy,
  input  logic              flush,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_nxt;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];
  logic             no_install;

  logic [IDX_W-1:0] idx, fill_idx;
  logic [TAG_W-1:0] tag, fill_tag;
  logic             hit, accept, fill_done, install;

  assign idx      = cpu_word_address[IDX_W-1:0];
  assign tag      = cpu_word_address[ADDR_W-1:IDX_W];
  assign fill_idx = flash_word_address[IDX_W-1:0];
  assign fill_tag = flash_word_address[ADDR_W-1:IDX_W];

  assign hit       = valid[idx] && (tag_mem[idx] == tag) && !flush;
  assign accept    = (state == IDLE) && cpu_rstrb;
  assign fill_done = (state == WAIT) && !flash_rbusy;
  // A flush anywhere in the miss, its final cycle included, keeps the word out of the array.
  assign install     = fill_done && !no_install && !flush;
  assign flash_rstrb = (state == REQ);

  // NOTE: next state gets a default before the case so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept && !hit) state_nxt = REQ;
      REQ:     state_nxt = WAIT;
      WAIT:    if (!flash_rbusy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      valid              <= '0;
      no_install         <= 1'b0;
      cpu_rbusy          <= 1'b0;
      cpu_rdata          <= '0;
      flash_word_address <= '0;
    end else begin
      state <= state_nxt;
      if (accept && hit) cpu_rdata <= data_mem[idx];
      if (accept && !hit) begin
        flash_word_address <= cpu_word_address;
        cpu_rbusy          <= 1'b1;
      end
      if (fill_done) begin
        cpu_rdata <= flash_rdata;
        cpu_rbusy <= 1'b0;
      end
      if (state_nxt == IDLE)              no_install <= 1'b0;
      else if (flush && state != IDLE)    no_install <= 1'b1;
      if (flush)        valid           <= '0;
      else if (install) valid[fill_idx] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays carry no reset; the valid bits alone decide whether a line is usable.
  always_ff @(posedge clk) begin
    if (install) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= flash_rdata;
    end
  end

`ifdef SPI_FLASH_CACHE_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (accept) begin
      if (hit && hit_cnt != 16'hFFFF)    hit_cnt  <= hit_cnt + 16'd1;
      if (!hit && miss_cnt != 16'hFFFF)  miss_cnt <= miss_cnt + 16'd1;
    end
  end

  assign hit_count  = hit_cnt;
  assign miss_count = miss_cnt;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule
